pulse_delay_gen: RTL and testbench



---
 rtl/pulse_delay_pkg.sv | 18 +
 rtl/pulse_delay_ch.sv | 100 ++++++++++
 rtl/pulse_delay_gen.sv | 37 +++
 tb/tb_pulse_delay_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_delay_pkg.sv
// Shared types and helpers for the multi-channel pulse delay generator.
package pulse_delay_pkg;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_DELAY = 2'd1,
    CH_PULSE = 2'd2
  } ch_state_e;

  localparam int DEFAULT_CNT_W   = 27;
  localparam int DEFAULT_PULSE_W = 1;

  // Width of a counter that must hold values 0..pw inclusive.
  function automatic int pwWidth(input int pw);
    return $clog2(pw + 1);
  endfunction

endpackage

// File: rtl/pulse_delay_ch.sv
// One channel: rising-edge trigger, programmable delay, fixed-width output pulse.
module pulse_delay_ch
  import pulse_delay_pkg::*;
#(
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int PULSE_W = DEFAULT_PULSE_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             din_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic             retrig_i,
  output logic             dout_o,
  output logic             busy_o,
  output logic             ovr_o
);

  localparam int PW_W = pwWidth(PULSE_W);

  ch_state_e        state_q;
  logic             dinPrev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] deff_q;
  logic [PW_W-1:0]  pwCnt_q;
  logic             trig;
  logic [CNT_W-1:0] deff_d;

  assign trig   = din_i & ~dinPrev_q;
  // A zero delay is treated as one cycle so the count loop always terminates.
  assign deff_d = (delay_i == '0) ? CNT_W'(1) : delay_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dinPrev_q <= 1'b1;
      state_q   <= CH_IDLE;
      cnt_q     <= '0;
      deff_q    <= '0;
      pwCnt_q   <= '0;
      dout_o    <= 1'b0;
      busy_o    <= 1'b0;
      ovr_o     <= 1'b0;
    end else begin
      dinPrev_q <= din_i;
      ovr_o     <= 1'b0;
      if (!en_i) begin
        state_q <= CH_IDLE;
        cnt_q   <= '0;
        pwCnt_q <= '0;
        dout_o  <= 1'b0;
        busy_o  <= 1'b0;
      end else begin
        case (state_q)
          CH_IDLE: begin
            if (trig) begin
              deff_q  <= deff_d;
              cnt_q   <= CNT_W'(1);
              state_q <= CH_DELAY;
              busy_o  <= 1'b1;
            end
          end
          CH_DELAY: begin
            // A retrigger wins even on the edge the delay would have expired.
            if (trig && retrig_i) begin
              deff_q <= deff_d;
              cnt_q  <= CNT_W'(1);
            end else begin
              ovr_o <= trig;
              if (cnt_q == deff_q) begin
                state_q <= CH_PULSE;
                dout_o  <= 1'b1;
                pwCnt_q <= PW_W'(1);
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          CH_PULSE: begin
            ovr_o <= trig;
            if (pwCnt_q == PW_W'(PULSE_W)) begin
              state_q <= CH_IDLE;
              cnt_q   <= '0;
              pwCnt_q <= '0;
              dout_o  <= 1'b0;
              busy_o  <= 1'b0;
            end else begin
              pwCnt_q <= pwCnt_q + PW_W'(1);
            end
          end
          default: begin
            state_q <= CH_IDLE;
            dout_o  <= 1'b0;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/pulse_delay_gen.sv
// Multi-channel pulse delay generator: independent channels sharing clock, reset and enable.
module pulse_delay_gen
  import pulse_delay_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int PULSE_W = DEFAULT_PULSE_W
) (
  input  logic                    clk_pdg,
  input  logic                    rst_pdg,
  input  logic                    en,
  input  logic [N_CH-1:0]         din,
  input  logic [N_CH*CNT_W-1:0]   delay,
  input  logic [N_CH-1:0]         retrig,
  output logic [N_CH-1:0]         dout,
  output logic [N_CH-1:0]         busy,
  output logic [N_CH-1:0]         ovr
);

  for (genvar k = 0; k < N_CH; k++) begin : gCh
    pulse_delay_ch #(
      .CNT_W   (CNT_W),
      .PULSE_W (PULSE_W)
    ) uCh (
      .clk_i    (clk_pdg),
      .rst_i    (rst_pdg),
      .en_i     (en),
      .din_i    (din[k]),
      .delay_i  (delay[k*CNT_W +: CNT_W]),
      .retrig_i (retrig[k]),
      .dout_o   (dout[k]),
      .busy_o   (busy[k]),
      .ovr_o    (ovr[k])
    );
  end

endmodule

// File: tb/tb_pulse_delay_gen.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-timestamp reference model.
module tb_pulse_delay_gen;

  localparam int N_CH    = 4;
  localparam int CNT_W   = 8;
  localparam int PULSE_W = 3;

  logic                  clk_pdg = 1'b0;
  logic                  rst_pdg;
  logic                  en;
  logic [N_CH-1:0]       din;
  logic [N_CH*CNT_W-1:0] delayBus;
  logic [N_CH-1:0]       retrig;
  logic [N_CH-1:0]       dout;
  logic [N_CH-1:0]       busy;
  logic [N_CH-1:0]       ovr;

  always #5 clk_pdg = ~clk_pdg;

  pulse_delay_gen #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .PULSE_W (PULSE_W)
  ) dut (
    .clk_pdg (clk_pdg),
    .rst_pdg (rst_pdg),
    .en      (en),
    .din     (din),
    .delay   (delayBus),
    .retrig  (retrig),
    .dout    (dout),
    .busy    (busy),
    .ovr     (ovr)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: each active channel remembers the edge its pulse starts and the edge it returns idle.
  bit              mActive  [N_CH];
  int              mPulseAt [N_CH];
  int              mEndAt   [N_CH];
  logic [N_CH-1:0] mPrev = '1;
  logic [N_CH-1:0] mDout = '0;
  logic [N_CH-1:0] mBusy = '0;
  logic [N_CH-1:0] mOvr  = '0;

  int firstDout [N_CH];
  int doutCount [N_CH];
  int ovrCount  [N_CH];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic modelStep();
    logic [N_CH-1:0] trig;
    int d;
    cyc++;
    mOvr = '0;
    if (rst_pdg) begin
      for (int k = 0; k < N_CH; k++) mActive[k] = 1'b0;
      mPrev = '1;
      mDout = '0;
      mBusy = '0;
      return;
    end
    trig  = din & ~mPrev;
    mPrev = din;
    if (!en) begin
      for (int k = 0; k < N_CH; k++) mActive[k] = 1'b0;
      mDout = '0;
      mBusy = '0;
      return;
    end
    for (int k = 0; k < N_CH; k++) begin
      d = int'(delayBus[k*CNT_W +: CNT_W]);
      if (d == 0) d = 1;
      if (mActive[k]) begin
        if (trig[k]) begin
          if (retrig[k] && cyc <= mPulseAt[k]) begin
            mPulseAt[k] = cyc + d;
            mEndAt[k]   = mPulseAt[k] + PULSE_W;
          end else begin
            mOvr[k] = 1'b1;
          end
        end
        if (cyc >= mEndAt[k]) mActive[k] = 1'b0;
      end else if (trig[k]) begin
        mActive[k]  = 1'b1;
        mPulseAt[k] = cyc + d;
        mEndAt[k]   = mPulseAt[k] + PULSE_W;
      end
      mBusy[k] = mActive[k];
      mDout[k] = mActive[k] && (cyc >= mPulseAt[k]);
    end
  endtask

  task automatic clearTrack();
    for (int k = 0; k < N_CH; k++) begin
      firstDout[k] = -1;
      doutCount[k] = 0;
      ovrCount[k]  = 0;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [N_CH-1:0] d,
                               input logic [N_CH-1:0] rt, input int n);
    for (int i = 0; i < n; i++) begin
      rst_pdg = r;
      en      = e;
      din     = d;
      retrig  = rt;
      @(posedge clk_pdg);
      modelStep();
      @(negedge clk_pdg);
      checkOutput("dout", 32'(dout), 32'(mDout));
      checkOutput("busy", 32'(busy), 32'(mBusy));
      checkOutput("ovr",  32'(ovr),  32'(mOvr));
      for (int k = 0; k < N_CH; k++) begin
        if (dout[k]) begin
          doutCount[k]++;
          if (firstDout[k] < 0) firstDout[k] = cyc;
        end
        if (ovr[k]) ovrCount[k]++;
      end
    end
  endtask

  task automatic setDelay(input int k, input int v);
    delayBus[k*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  int e0;

  initial begin
    rst_pdg  = 1'b1;
    en       = 1'b1;
    din      = '0;
    retrig   = '0;
    delayBus = '0;
    for (int k = 0; k < N_CH; k++) mActive[k] = 1'b0;

    // Trigger held high through reset must not fire; then a clean edge with delay 5.
    setDelay(0, 5);
    applyStimulus(1'b1, 1'b1, 4'b0001, 4'b0000, 3);
    clearTrack();
    applyStimulus(1'b0, 1'b1, 4'b0001, 4'b0000, 6);
    checkOutput("heldHighNoPulse", 32'(doutCount[0]), 32'd0);
    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000, 1);
    applyStimulus(1'b0, 1'b1, 4'b0001, 4'b0000, 1);
    e0 = cyc;
    applyStimulus(1'b0, 1'b1, 4'b0001, 4'b0000, 12);
    checkOutput("d5Latency", 32'(firstDout[0] - e0), 32'd5);
    checkOutput("d5Width", 32'(doutCount[0]), 32'(PULSE_W));

    // Zero delay on channel 1 behaves as one cycle.
    setDelay(1, 0);
    clearTrack();
    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000, 2);
    applyStimulus(1'b0, 1'b1, 4'b0010, 4'b0000, 1);
    e0 = cyc;
    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000, 8);
    checkOutput("d0Latency", 32'(firstDout[1] - e0), 32'd1);
    checkOutput("d0Width", 32'(doutCount[1]), 32'(PULSE_W));

    // Second edge during the delay: dropped without retrig, restarts with retrig.
    for (int mode = 0; mode < 2; mode++) begin
      setDelay(0, 10);
      clearTrack();
      applyStimulus(1'b0, 1'b1, 4'b0000, 4'(mode), 2);
      applyStimulus(1'b0, 1'b1, 4'b0001, 4'(mode), 1);
      e0 = cyc;
      applyStimulus(1'b0, 1'b1, 4'b0001, 4'(mode), 1);
      applyStimulus(1'b0, 1'b1, 4'b0000, 4'(mode), 2);
      applyStimulus(1'b0, 1'b1, 4'b0001, 4'(mode), 1);
      applyStimulus(1'b0, 1'b1, 4'b0000, 4'(mode), 20);
      checkOutput(mode == 0 ? "noRetrigLatency" : "retrigLatency",
                  32'(firstDout[0] - e0), mode == 0 ? 32'd10 : 32'd14);
      checkOutput(mode == 0 ? "noRetrigOvr" : "retrigOvr",
                  32'(ovrCount[0]), mode == 0 ? 32'd1 : 32'd0);
    end

    // Trigger inside the pulse is dropped and does not shorten it.
    setDelay(2, 2);
    clearTrack();
    applyStimulus(1'b0, 1'b1, 4'b0100, 4'b0100, 1);
    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0100, 2);
    applyStimulus(1'b0, 1'b1, 4'b0100, 4'b0100, 1);
    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0100, 6);
    checkOutput("pulseOvr", 32'(ovrCount[2]), 32'd1);
    checkOutput("pulseWidth", 32'(doutCount[2]), 32'(PULSE_W));

    // Abort mid-delay, then re-enable with the trigger still high.
    setDelay(3, 100);
    clearTrack();
    applyStimulus(1'b0, 1'b1, 4'b1000, 4'b0000, 50);
    applyStimulus(1'b0, 1'b0, 4'b1000, 4'b0000, 5);
    applyStimulus(1'b0, 1'b1, 4'b1000, 4'b0000, 110);
    checkOutput("abortNoPulse", 32'(doutCount[3]), 32'd0);

    // All channels on one edge, delay ports scrambled mid-count.
    for (int k = 0; k < N_CH; k++) setDelay(k, k + 1);
    clearTrack();
    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000, 2);
    applyStimulus(1'b0, 1'b1, 4'b1111, 4'b0000, 1);
    e0 = cyc;
    for (int k = 0; k < N_CH; k++) setDelay(k, 40);
    applyStimulus(1'b0, 1'b1, 4'b1111, 4'b0000, 12);
    for (int k = 0; k < N_CH; k++) begin
      checkOutput($sformatf("staggerLatency%0d", k), 32'(firstDout[k] - e0), 32'(k + 1));
      checkOutput($sformatf("staggerWidth%0d", k), 32'(doutCount[k]), 32'(PULSE_W));
    end

    // Largest delay the counter can hold.
    setDelay(2, 255);
    clearTrack();
    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000, 1);
    applyStimulus(1'b0, 1'b1, 4'b0100, 4'b0000, 1);
    e0 = cyc;
    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000, 262);
    checkOutput("maxDelayLatency", 32'(firstDout[2] - e0), 32'd255);

    // Random traffic, model-checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N_CH; k++) setDelay(k, int'($urandom_range(0, 12)));
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) != 0),
                    N_CH'($urandom), N_CH'($urandom), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
